// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD combinational read ports with write bypass,
// two prioritised write ports, a post-reset init sequencer and a per-register pending scoreboard.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 32,
  parameter int NREAD   = 2,
  parameter int SP_IDX  = 2,
  parameter int SP_INIT = 255,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   read_reg,
  output logic [NREAD*XLEN-1:0] read_data,
  output logic [NREAD-1:0]      read_pending,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [AW-1:0]         wreg0,
  input  logic [AW-1:0]         wreg1,
  input  logic [XLEN-1:0]       wdata0,
  input  logic [XLEN-1:0]       wdata1,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_reg,
  input  logic                  flush,
  output logic                  ready
);

  typedef enum logic {INIT, READY} state_t;

  state_t            r_state, w_next_state;
  logic [AW-1:0]     r_init_idx;
  logic              r_ready;
  logic [XLEN-1:0]   r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic w_run, w_wr0, w_wr1, w_init_last;

  assign w_run       = (r_state == READY);
  assign w_wr0       = w_run && we0 && (wreg0 != '0);
  assign w_wr1       = w_run && we1 && (wreg1 != '0);
  assign w_init_last = (r_init_idx == AW'(DEPTH - 1));
  assign ready       = r_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT:    if (w_init_last) w_next_state = READY;
      READY:   w_next_state = READY;
      default: w_next_state = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_idx <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == READY);
      if (r_state == INIT) r_init_idx <= r_init_idx + 1'b1;
    end
  end

  // Array has no reset: the init sequencer overwrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_regs[r_init_idx] <= (r_init_idx == AW'(SP_IDX)) ? XLEN'(SP_INIT) : '0;
    end else begin
      if (w_wr0) r_regs[wreg0] <= wdata0;
      if (w_wr1) r_regs[wreg1] <= wdata1;
    end
  end

  // Issue beats flush beats write-clear; entry 0 never goes pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else if (w_run) begin
      r_pend[0] <= 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
        if (issue_valid && issue_reg == AW'(r))
          r_pend[r] <= 1'b1;
        else if (flush)
          r_pend[r] <= 1'b0;
        else if ((w_wr0 && wreg0 == AW'(r)) || (w_wr1 && wreg1 == AW'(r)))
          r_pend[r] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0]   w_rr;
    logic [XLEN-1:0] w_rd;
    logic            w_pd;

    assign w_rr = read_reg[g*AW +: AW];

    always_comb begin
      w_rd = '0;
      if (w_run && w_rr != '0) begin
        if (we1 && wreg1 == w_rr)      w_rd = wdata1;
        else if (we0 && wreg0 == w_rr) w_rd = wdata0;
        else                           w_rd = r_regs[w_rr];
      end
    end

    // A write landing this cycle bypasses its data, so the hazard is already resolved.
    assign w_pd = w_run && r_pend[w_rr]
               && !(w_wr0 && wreg0 == w_rr) && !(w_wr1 && wreg1 == w_rr);

    assign read_data[g*XLEN +: XLEN] = w_rd;
    assign read_pending[g]           = w_pd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: an abstract register/pending model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_regfile_mp;
  localparam int XLEN = 32, DEPTH = 32, NREAD = 2, AW = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREAD-1:0][AW-1:0] rr;
  logic [NREAD*XLEN-1:0] read_data;
  logic [NREAD-1:0]      read_pending;
  logic                  we0, we1, issue_valid, flush, ready;
  logic [AW-1:0]         wreg0, wreg1, issue_reg;
  logic [XLEN-1:0]       wdata0, wdata1;

  int n_vec  = 0;
  int n_miss = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .read_reg(rr), .read_data(read_data),
    .read_pending(read_pending), .we0(we0), .we1(we1), .wreg0(wreg0),
    .wreg1(wreg1), .wdata0(wdata0), .wdata1(wdata1), .issue_valid(issue_valid),
    .issue_reg(issue_reg), .flush(flush), .ready(ready)
  );

  always #5 clk = ~clk;

  // Model: contents become the init image at reset (not observable until ready),
  // ready is simply "DEPTH edges have passed since release".
  logic [XLEN-1:0] m_regs [DEPTH];
  bit              m_pend [DEPTH];
  int              m_cyc;

  function automatic bit m_ready();
    return m_cyc >= DEPTH;
  endfunction

  function automatic bit m_writes(int r);
    return (we0 && int'(wreg0) == r && r != 0) || (we1 && int'(wreg1) == r && r != 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0;
      for (int r = 0; r < DEPTH; r++) begin
        m_regs[r] = (r == 2) ? 32'd255 : 32'd0;
        m_pend[r] = 1'b0;
      end
    end else if (!m_ready()) begin
      m_cyc++;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (issue_valid && int'(issue_reg) == r) m_pend[r] = 1'b1;
        else if (flush || m_writes(r))           m_pend[r] = 1'b0;
      end
      if (we0 && wreg0 != 0) m_regs[wreg0] = wdata0;
      if (we1 && wreg1 != 0) m_regs[wreg1] = wdata1;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(int r);
    if (!m_ready() || r == 0)        return '0;
    if (we1 && int'(wreg1) == r)     return wdata1;
    if (we0 && int'(wreg0) == r)     return wdata0;
    return m_regs[r];
  endfunction

  task automatic chk(string nm, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_ready", {31'd0, ready}, {31'd0, m_ready()});
    for (int p = 0; p < NREAD; p++) begin
      chk("m_rdata", read_data[p*XLEN +: XLEN], exp_data(int'(rr[p])));
      chk("m_rpend", {31'd0, read_pending[p]},
          {31'd0, m_ready() && m_pend[rr[p]] && !m_writes(int'(rr[p]))});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; issue_valid = 0; flush = 0;
  endtask

  // Hold reset for hold_cyc edges, then run the init window poking we0 and checking ready timing.
  task automatic do_init(int hold_cyc);
    rst = 1'b1;
    #1 chk("rst_ready", {31'd0, ready}, 32'd0);
    repeat (hold_cyc) step();
    rst = 1'b0;
    rr[0] = 5'd5;
    for (int i = 0; i < DEPTH; i++) begin
      we0 = i[0]; wreg0 = 5'd5; wdata0 = $urandom;
      #1 chk("init_ready_lo", {31'd0, ready}, 32'd0);
      chk("init_rdata0", read_data[31:0], 32'd0);
      step();
    end
    idle();
    #1 chk("init_ready_hi", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rr = '0; idle();
    wreg0 = '0; wreg1 = '0; wdata0 = '0; wdata1 = '0; issue_reg = '0;
    #1;
    do_init(2);

    for (int r = 0; r < DEPTH; r++) begin
      rr[0] = AW'(r); rr[1] = AW'(DEPTH - 1 - r);
      #1 chk("init_val", read_data[31:0], (r == 2) ? 32'd255 : 32'd0);
      step();
    end

    // Same-cycle double write: younger port wins, bypass and array agree.
    rr[0] = 5'd5; rr[1] = 5'd6;
    we0 = 1; wreg0 = 5'd5; wdata0 = 32'h11;
    we1 = 1; wreg1 = 5'd5; wdata1 = 32'h22;
    #1 chk("byp_prio", read_data[31:0], 32'h22);
    step(); idle();
    #1 chk("arr_prio", read_data[31:0], 32'h22);
    we0 = 1; wreg0 = 5'd6; wdata0 = 32'h66;
    #1 chk("byp_w0", read_data[63:32], 32'h66);
    step(); idle();

    // Register zero.
    rr[0] = 5'd0; we0 = 1; wreg0 = 5'd0; wdata0 = 32'hDEAD;
    issue_valid = 1; issue_reg = 5'd0;
    #1 chk("r0_byp", read_data[31:0], 32'd0);
    step(); idle();
    #1 chk("r0_arr", read_data[31:0], 32'd0);
    chk("r0_pend", {31'd0, read_pending[0]}, 32'd0);

    // Scoreboard set / write-clear / set-beats-clear.
    rr[0] = 5'd7; issue_valid = 1; issue_reg = 5'd7;
    step(); idle();
    #1 chk("sb_set", {31'd0, read_pending[0]}, 32'd1);
    we1 = 1; wreg1 = 5'd7; wdata1 = 32'h77;
    #1 chk("sb_mask", {31'd0, read_pending[0]}, 32'd0);
    chk("sb_byp", read_data[31:0], 32'h77);
    step(); idle();
    #1 chk("sb_clr", {31'd0, read_pending[0]}, 32'd0);
    chk("sb_arr", read_data[31:0], 32'h77);
    issue_valid = 1; issue_reg = 5'd7; we1 = 1; wreg1 = 5'd7; wdata1 = 32'h78;
    step(); idle();
    #1 chk("sb_setwin", {31'd0, read_pending[0]}, 32'd1);
    chk("sb_arr2", read_data[31:0], 32'h78);

    // Flush races an issue.
    issue_valid = 1; issue_reg = 5'd3; step();
    issue_reg = 5'd4; step();
    issue_reg = 5'd9; flush = 1; step(); idle();
    rr[0] = 5'd3; rr[1] = 5'd9;
    #1 chk("fl_r3", {31'd0, read_pending[0]}, 32'd0);
    chk("fl_r9", {31'd0, read_pending[1]}, 32'd1);
    rr[0] = 5'd4; rr[1] = 5'd7;
    #1 chk("fl_r4", {31'd0, read_pending[0]}, 32'd0);
    chk("fl_r7", {31'd0, read_pending[1]}, 32'd0);
    step();

    // Reset in the middle of a write stream.
    rr[0] = 5'd6; we0 = 1; wreg0 = 5'd6; wdata0 = 32'h55;
    step();
    wdata0 = 32'h56;
    #1 chk("mid_pre", read_data[31:0], 32'h56);
    we0 = 0;
    #1 chk("mid_arr", read_data[31:0], 32'h55);
    we0 = 1; wdata0 = 32'h57;
    do_init(1);
    rr[0] = 5'd6; rr[1] = 5'd2;
    #1 chk("mid_r6", read_data[31:0], 32'd0);
    chk("mid_sp", read_data[63:32], 32'd255);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined CPU, replacing the single-write, two-read file. It provides NREAD combinational read ports, two prioritised write ports with same-cycle bypass, and a hardware init sequencer that loads reset values after reset. It also keeps a per-register pending scoreboard that the decode stage uses for hazard detection.

## Interface
- XLEN, 32: data width
- DEPTH, 32: number of registers (power of 2, ≥4); AW = log2(DEPTH)
- NREAD, 2: number of read ports (1..4)
- SP_IDX, 2: index of the stack pointer
- SP_INIT, 255: value loaded into SP_IDX during init

- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset: asynchronous, active-high
- read_reg  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW]
- read_data  out  NREAD*XLEN  read data for port i
- read_pending  out  NREAD  port i's register has an outstanding producer
- we0, we1  in  1  write enables; port 1 is the younger instruction
- wreg0, wreg1  in  AW  write addresses
- wdata0, wdata1  in  XLEN  write data
- issue_valid  in  1  mark issue_reg pending (a producer was dispatched)
- issue_reg  in  AW  destination register of the dispatched producer
- flush  in  1  clear all pending bits
- ready  out  1  init complete; writes, issues and reads are valid

## Operation
- States: INIT, READY.
- rst asserted: state←INIT, init_idx←0, all pending bits←0, ready←0. Array contents are not reset directly.
- INIT:
  - Each cycle writes regs[init_idx] ← (init_idx==SP_IDX ? SP_INIT : 0) and increments init_idx.
  - After writing index DEPTH-1: state←READY, ready←1.
  - we0/we1, issue_valid and flush are ignored.
  - read_data is all 0 and read_pending is all 0.
- READY writes:
  - Port k with wek=1 and wregk≠0 writes wdatak to regs[wregk] at the edge.
  - If both ports hit the same register, port 1 wins.
  - Writes to register 0 are discarded.
- Reads are combinational. For each port, priority order:
  1. read_reg==0 → 0, with no bypass.
  2. we1 && wreg1==read_reg → wdata1.
  3. we0 && wreg0==read_reg → wdata0.
  4. Otherwise regs[read_reg].
- Scoreboard:
  - Next-state of pending[r], in priority order: set if issue_valid && issue_reg==r && r≠0; else 0 if flush; else 0 if a write port writes r this cycle; else hold.
  - A set in the same cycle as a clearing write or flush wins.
  - pending[0] is always 0.
- read_pending[i] = pending[read_reg_i] && no write port writes read_reg_i this cycle (the data is bypassed).
- Reset mid-operation: returns to INIT immediately. The init sequence reruns in full and any in-flight writes are lost.

## Timing
- Init latency: the first rising edge after rst deasserts writes index 0. ready goes high after the DEPTH-th edge, i.e. DEPTH cycles after reset release.
- Write-to-read latency: 0 cycles via bypass; from the array, 1 edge.
- Issue-to-pending latency: 1 edge. Write clears pending at the same edge and masks read_pending combinationally in the write cycle.
- All outputs are combinational from state and inputs; no registered outputs except ready.
- Reset values: ready=0, read_pending=0, read_data=0.

## Test plan
- Init: pulse rst, then run DEPTH=32 cycles. ready rises exactly 32 cycles after release; reg 2 reads 255 and regs 1 and 3..31 read 0. Toggling we0 during INIT leaves contents unchanged.
- Bypass and priority: in READY, we0 (r5, 0x11) and we1 (r5, 0x22) in the same cycle. read_reg=5 shows 0x22 the same cycle and 0x22 the next cycle.
- Register zero: we0 (r0, 0xDEAD) with read_reg=0 reads 0 in the same cycle and afterwards. issue_valid to r0 leaves read_pending=0.
- Scoreboard: issue r7, then read_pending=1 next cycle. The cycle we1 writes r7 gives read_pending=0 and read_data=wdata1. issue r7 together with a write to r7 leaves pending=1.
- Flush: issue r3 and r4, then flush together with issue r9. Only r9 is pending afterwards.
- Reset mid-operation: write r6=0x55, assert rst for 1 cycle mid-write. After re-init, r6 reads 0 and ready re-asserts after 32 cycles.
